// File: rtl/uart_tx_serializer_if.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer_if
//   Byte handshake between the TX holding/FIFO stage (master) and the
//   transmit shift stage (slave).
//   tx_valid : master has a byte on tx_data
//   tx_data  : byte to send (bits above the active word length are unused)
//   tx_ready : slave accepts the byte on this PCLK edge
// ---------------------------------------------------------------------------
interface uart_tx_serializer_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (output tx_valid, output tx_data, input  tx_ready);
  modport slave  (input  tx_valid, input  tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//   Transmit shift stage of a 16550-compatible UART. Pulls one byte per
//   frame from the holding stage and serializes it on TXD as
//   start / 5-8 data bits LSB first / optional parity / 1, 1.5 or 2 stop.
//
// Ports
//   PCLK, PRESET        clock, synchronous active-high reset
//   tx_if (slave)       byte handshake (valid / data / ready)
//   i_baud_tick         OVERSAMPLE pulses per bit period
//   i_word_length       00=5 .. 11=8 data bits
//   i_num_of_stop_bits  0=1 stop, 1=2 stop (1.5 with 5-bit words)
//   i_parity_en         parity bit present
//   i_odd_even_parity   1=even, 0=odd
//   i_sticky_parity_en  parity bit forced to ~i_odd_even_parity
//   i_break_ctrl_bit    live break, forces TXD low
//   o_txd               registered serial output, idle mark = 1
//   o_tsr_empty         no frame in progress
//   o_frame_done        one-cycle pulse after the last stop bit
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = $clog2(OVERSAMPLE*3/2)
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  uart_tx_serializer_if.slave        tx_if,
  input  logic                       i_baud_tick,
  input  logic [1:0]                 i_word_length,
  input  logic                       i_num_of_stop_bits,
  input  logic                       i_parity_en,
  input  logic                       i_odd_even_parity,
  input  logic                       i_sticky_parity_en,
  input  logic                       i_break_ctrl_bit,
  output logic                       o_txd,
  output logic                       o_tsr_empty,
  output logic                       o_frame_done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  // Line control snapshot taken when a byte is accepted; the running frame
  // never sees LCR writes that land after acceptance.
  typedef struct packed {
    logic [2:0] last_bit;   // index of the final data bit (4..7)
    logic       pen;
    logic       par_bit;    // parity value, resolved at capture time
    logic       two_stop;   // second stop period present
    logic       half_stop;  // second stop period is only half a bit
  } cfg_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tick_q,  tick_d;
  logic [2:0]       bit_q,   bit_d;
  logic [7:0]       shift_q, shift_d;
  cfg_t             cfg_q,   cfg_d;
  logic             txd_q,   txd_d;
  logic             done_q,  done_d;

  // Parity is computed from the byte as presented at acceptance so the
  // shift register can be consumed destructively during DATA.
  logic [7:0] data_mask;
  logic       ones_odd;
  logic       par_new;

  assign data_mask = 8'hFF >> (2'd3 - i_word_length);
  assign ones_odd  = ^(tx_if.tx_data & data_mask);
  assign par_new   = i_sticky_parity_en ? ~i_odd_even_parity
                   : (i_odd_even_parity ? ones_odd : ~ones_odd);

  // STOP reuses bit_q to count stop periods; with 1.5 stop bits the second
  // period ends after half a bit, which keeps the tick counter below
  // OVERSAMPLE in every state.
  logic half_bit;
  logic bit_end;

  assign half_bit = (state_q == STOP) && cfg_q.half_stop && (bit_q == 3'd1);
  assign bit_end  = i_baud_tick &&
                    (tick_q == (half_bit ? CNT_W'(OVERSAMPLE/2 - 1)
                                         : CNT_W'(OVERSAMPLE - 1)));

  assign tx_if.tx_ready = (state_q == IDLE);
  assign o_tsr_empty    = (state_q == IDLE);
  assign o_txd          = txd_q;
  assign o_frame_done   = done_q;

  // Next-state / datapath
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    cfg_d   = cfg_q;
    done_d  = 1'b0;

    if (state_q == IDLE) begin
      // Baud ticks in IDLE are ignored so the first bit is never short.
      tick_d = '0;
      bit_d  = '0;
      if (tx_if.tx_valid) begin
        state_d            = START;
        shift_d            = tx_if.tx_data;
        cfg_d.last_bit     = {1'b1, i_word_length};
        cfg_d.pen          = i_parity_en;
        cfg_d.par_bit      = par_new;
        cfg_d.two_stop     = i_num_of_stop_bits;
        cfg_d.half_stop    = i_num_of_stop_bits && (i_word_length == 2'b00);
      end
    end else if (i_baud_tick) begin
      if (!bit_end) begin
        tick_d = tick_q + 1'b1;
      end else begin
        tick_d = '0;
        case (state_q)
          START: begin
            state_d = DATA;
            bit_d   = '0;
          end
          DATA: begin
            shift_d = {1'b0, shift_q[7:1]};
            if (bit_q == cfg_q.last_bit) begin
              bit_d   = '0;
              state_d = cfg_q.pen ? PARITY : STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
          PARITY: begin
            state_d = STOP;
            bit_d   = '0;
          end
          STOP: begin
            if (bit_q == {2'b00, cfg_q.two_stop}) begin
              state_d = IDLE;
              bit_d   = '0;
              done_d  = 1'b1;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // TXD is registered from the next state so the line changes on the same
  // edge the FSM advances; break is applied live on top of the frame.
  logic line_d;

  always_comb begin
    line_d = 1'b1;
    case (state_d)
      START:   line_d = 1'b0;
      DATA:    line_d = shift_d[0];
      PARITY:  line_d = cfg_d.par_bit;
      default: line_d = 1'b1;
    endcase
    txd_d = i_break_ctrl_bit ? 1'b0 : line_d;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      cfg_q   <= '0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      cfg_q   <= cfg_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;
  localparam int OS = 16;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       baud;
  logic [1:0] lcr_wl;
  logic       lcr_stop, lcr_pen, lcr_eps, lcr_stick, brk;
  logic       o_txd, o_tsr_empty, o_frame_done;

  uart_tx_serializer_if tx_if();

  uart_tx_serializer #(.OVERSAMPLE(OS)) dut (
    .PCLK               (PCLK),
    .PRESET             (PRESET),
    .tx_if              (tx_if),
    .i_baud_tick        (baud),
    .i_word_length      (lcr_wl),
    .i_num_of_stop_bits (lcr_stop),
    .i_parity_en        (lcr_pen),
    .i_odd_even_parity  (lcr_eps),
    .i_sticky_parity_en (lcr_stick),
    .i_break_ctrl_bit   (brk),
    .o_txd              (o_txd),
    .o_tsr_empty        (o_tsr_empty),
    .o_frame_done       (o_frame_done)
  );

  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;

  // Expected line level for every baud tick of the frame, tick 0 first.
  logic exp_q[$];

  function automatic void build(input logic [7:0] d, input logic [1:0] wl,
                                input logic stp, pen, eps, stick);
    int  nb;
    int  ones;
    int  stop_len;
    logic par;
    nb   = 5 + int'(wl);
    ones = 0;
    exp_q.delete();
    repeat (OS) exp_q.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      repeat (OS) exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    // even parity: bit makes the total count of ones even
    par = stick ? ~eps : (eps ? (ones % 2 == 1) : (ones % 2 == 0));
    if (pen) repeat (OS) exp_q.push_back(par);
    stop_len = !stp ? OS : ((wl == 2'b00) ? OS * 3 / 2 : 2 * OS);
    repeat (stop_len) exp_q.push_back(1'b1);
  endfunction

  // Offers one byte, then runs the frame with random baud ticks, checking
  // {txd, ready, empty, done} after every PCLK edge against the model.
  task automatic play_frame(input logic [7:0] d, input logic [1:0] wl,
                            input logic stp, pen, eps, stick,
                            input int brk_from, brk_to, flip_at, rst_at,
                            input logic hold, input logic [7:0] nd,
                            output int waited, output int ticks);
    int t, n;
    logic tk, br, rst, flipped;
    logic [3:0] got, exp;
    @(negedge PCLK);
    lcr_wl = wl; lcr_stop = stp; lcr_pen = pen; lcr_eps = eps; lcr_stick = stick;
    tx_if.tx_valid = 1'b1; tx_if.tx_data = d; brk = 1'b0;
    baud = 1'($urandom_range(0, 1));
    waited = 0;
    while (tx_if.tx_ready !== 1'b1 && waited < 1000) begin
      @(negedge PCLK);
      baud = 1'($urandom_range(0, 1));
      waited++;
    end
    if (waited >= 1000) begin
      total++; bad++;
      $display("FAIL accept_timeout ready=%b want 1", tx_if.tx_ready);
      ticks = 0;
      return;
    end
    build(d, wl, stp, pen, eps, stick);
    n = exp_q.size();
    @(posedge PCLK);
    t = 0; flipped = 1'b0;
    for (int g = 0; g < 20 * n; g++) begin
      @(negedge PCLK);
      if (hold) tx_if.tx_data = nd; else tx_if.tx_valid = 1'b0;
      tk  = ($urandom_range(0, 3) != 0);
      br  = (t >= brk_from && t < brk_to);
      rst = (t == rst_at);
      if (t == flip_at && !flipped) begin lcr_eps = ~lcr_eps; flipped = 1'b1; end
      baud = tk; brk = br; PRESET = rst;
      @(posedge PCLK); #1;
      got = {o_txd, tx_if.tx_ready, o_tsr_empty, o_frame_done};
      if (rst) begin
        PRESET = 1'b0;
        total++;
        if (got !== 4'b1110) begin
          bad++;
          $display("FAIL reset_mid_frame txd/rdy/empty/done=%b want 1110", got);
        end
        ticks = t;
        return;
      end
      if (tk) t++;
      if (t < n) exp = {(br ? 1'b0 : exp_q[t]), 3'b000};
      else       exp = {~br, 3'b111};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL frame_bit data=%h tick=%0d txd/rdy/empty/done=%b want %b", d, t, got, exp);
      end
      if (t >= n) break;
    end
    ticks = t;
    if (t < n) begin
      total++; bad++;
      $display("FAIL frame_timeout ticks=%0d want %0d", t, n);
    end
  endtask

  task automatic test_reset();
    lcr_wl = 2'b11; lcr_stop = 1'b1; lcr_pen = 1'b1; lcr_eps = 1'b1; lcr_stick = 1'b0;
    tx_if.tx_valid = 1'b1; tx_if.tx_data = 8'hFF; baud = 1'b1; brk = 1'b1; PRESET = 1'b1;
    repeat (3) begin
      @(posedge PCLK); #1;
      total++;
      if ({o_txd, tx_if.tx_ready, o_tsr_empty, o_frame_done} !== 4'b1110) begin
        bad++;
        $display("FAIL reset_state txd/rdy/empty/done=%b want 1110",
                 {o_txd, tx_if.tx_ready, o_tsr_empty, o_frame_done});
      end
    end
    @(negedge PCLK);
    PRESET = 1'b0; tx_if.tx_valid = 1'b0; brk = 1'b0;
    repeat (4) begin
      @(posedge PCLK); #1;
      total++;
      if ({o_txd, tx_if.tx_ready, o_tsr_empty, o_frame_done} !== 4'b1110) begin
        bad++;
        $display("FAIL idle_after_reset txd/rdy/empty/done=%b want 1110",
                 {o_txd, tx_if.tx_ready, o_tsr_empty, o_frame_done});
      end
    end
  endtask

  task automatic test_frame_len(input string nm, input logic [7:0] d, input logic [1:0] wl,
                                input logic stp, pen, eps, stick, input int want);
    int w, tk;
    play_frame(d, wl, stp, pen, eps, stick, -1, -1, -1, -1, 1'b0, 8'h00, w, tk);
    total++;
    if (tk !== want) begin
      bad++;
      $display("FAIL %s frame_ticks=%0d want %0d", nm, tk, want);
    end
  endtask

  task automatic test_formats();
    test_frame_len("8N1",      8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 160);
    test_frame_len("7E1",      8'hC1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 160);
    test_frame_len("5O1.5",    8'h1F, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 136);
    test_frame_len("8O2",      8'h1F, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 192);
  endtask

  task automatic test_stick_snapshot();
    int w, tk;
    play_frame(8'h00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, -1, -1, -1, -1, 1'b0, 8'h00, w, tk);
    play_frame(8'h01, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, -1, -1, -1, -1, 1'b0, 8'h00, w, tk);
    // EPS flips during DATA; this frame keeps odd parity, next uses even
    play_frame(8'h07, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1, 40, -1, 1'b0, 8'h00, w, tk);
    play_frame(8'h07, 2'b11, 1'b0, 1'b1, lcr_eps, 1'b0, -1, -1, -1, -1, 1'b0, 8'h00, w, tk);
    total++;
    if (lcr_eps !== 1'b1) begin
      bad++;
      $display("FAIL snapshot_eps_live eps=%b want 1", lcr_eps);
    end
  endtask

  task automatic test_back_to_back();
    int w1, w2, tk;
    play_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, -1, -1, 1'b1, 8'hAA, w1, tk);
    play_frame(8'hAA, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, -1, -1, 1'b0, 8'h00, w2, tk);
    total++;
    if (w2 !== 0) begin
      bad++;
      $display("FAIL back_to_back_gap extra_idle_cycles=%0d want 0", w2);
    end
    repeat (20) begin
      @(negedge PCLK); baud = 1'b1;
      @(posedge PCLK); #1;
      total++;
      if ({o_txd, o_tsr_empty, o_frame_done} !== 3'b110) begin
        bad++;
        $display("FAIL no_third_frame txd/empty/done=%b want 110", {o_txd, o_tsr_empty, o_frame_done});
      end
    end
  endtask

  task automatic test_break();
    int w, tk;
    play_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 20, 100, -1, -1, 1'b0, 8'h00, w, tk);
    total++;
    if (tk !== 160) begin
      bad++;
      $display("FAIL break_frame_ticks=%0d want 160", tk);
    end
  endtask

  task automatic test_reset_mid();
    int w, tk;
    play_frame(8'h96, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, -1, -1, -1, 150, 1'b0, 8'h00, w, tk);
    repeat (40) begin
      @(negedge PCLK); baud = 1'b1; tx_if.tx_valid = 1'b0;
      @(posedge PCLK); #1;
      total++;
      if ({o_txd, tx_if.tx_ready, o_tsr_empty, o_frame_done} !== 4'b1110) begin
        bad++;
        $display("FAIL aborted_frame_resumed txd/rdy/empty/done=%b want 1110",
                 {o_txd, tx_if.tx_ready, o_tsr_empty, o_frame_done});
      end
    end
    test_frame_len("after_reset", 8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 160);
  endtask

  task automatic test_random();
    int w, tk, bf, bt;
    for (int i = 0; i < 10; i++) begin
      bf = -1; bt = -1;
      if ($urandom_range(0, 2) == 0) begin
        bf = $urandom_range(0, 60);
        bt = bf + $urandom_range(1, 40);
      end
      play_frame(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), bf, bt, -1, -1, 1'b0, 8'h00, w, tk);
    end
  endtask

  initial begin
    tx_if.tx_valid = 1'b0; tx_if.tx_data = 8'h00;
    baud = 1'b0; brk = 1'b0; PRESET = 1'b1;
    lcr_wl = 2'b00; lcr_stop = 1'b0; lcr_pen = 1'b0; lcr_eps = 1'b0; lcr_stick = 1'b0;
    test_reset();
    test_formats();
    test_stick_snapshot();
    test_back_to_back();
    test_break();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Transmit shift stage of the 16550-compatible UART.
- Sits downstream of the APB register file (LCR fields) and the TX holding/FIFO stage. Pulls one byte per frame over a valid/ready handshake and serializes it on the TXD line.
- Frame layout: start bit, 5–8 data bits LSB first, optional parity bit, then 1, 1.5 or 2 stop bits. Bit timing comes from an oversampled baud tick.

Parameters:
OVERSAMPLE, 16, baud ticks per bit period; must be even and >= 4
CNT_W, $clog2(OVERSAMPLE*3/2), width of the tick counter; must cover the 1.5-stop-bit length

Ports:
PCLK  in  1  system clock
PRESET  in  1  synchronous, active-high reset
i_baud_tick  in  1  one-PCLK-cycle enable, OVERSAMPLE pulses per bit period
i_tx_valid  in  1  TX holding/FIFO has a byte
i_tx_data  in  8  byte to send; bits above word length ignored
o_tx_ready  out  1  serializer accepts a byte this cycle
i_word_length  in  2  00=5, 01=6, 10=7, 11=8 data bits
i_num_of_stop_bits  in  1  0 = 1 stop bit; 1 = 2 stop bits (1.5 when 5-bit word)
i_parity_en  in  1  parity bit present
i_odd_even_parity  in  1  1 = even, 0 = odd
i_sticky_parity_en  in  1  stick parity: bit value = ~i_odd_even_parity
i_break_ctrl_bit  in  1  force TXD low
o_txd  out  1  serial output; idle mark = 1
o_tsr_empty  out  1  no frame in progress (feeds LSR TEMT)
o_frame_done  out  1  single-cycle pulse at the end of the last stop bit

Behaviour:
- Clock/reset: one clock, PCLK. Reset PRESET is synchronous and active-high. It takes priority over all other inputs.
- Reset values, applied on the first PCLK edge with PRESET=1, including mid-frame:
  - state=IDLE; o_txd=1; o_tx_ready=1; o_tsr_empty=1; o_frame_done=0.
  - Tick counter, bit counter and shift register all cleared.
  - An aborted frame is not resumed.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - o_tx_ready=1 and o_tsr_empty=1.
  - When i_tx_valid && o_tx_ready: capture i_tx_data into the shift register, and snapshot all LCR inputs into internal frame config.
  - Next cycle: state=START, o_txd=0, tick counter=0.
  - LCR changes mid-frame take effect on the next frame only.
- Bit timing:
  - Tick counter increments only on i_baud_tick.
  - A bit period ends on the i_baud_tick that arrives while counter==OVERSAMPLE-1. The counter then returns to 0 and the state/bit advances on that same edge.
  - Ticks are counted strictly after state entry, so every bit lasts exactly OVERSAMPLE ticks.
- START → DATA: o_txd=0 for one bit period.
- DATA:
  - o_txd = shift register bit 0; shift right at the end of each bit.
  - Bit counter runs to word length (5/6/7/8).
  - Next state is PARITY if the snapshotted parity enable is set, else STOP.
- PARITY (one bit period):
  - sticky=1: bit = ~odd_even.
  - else even: XOR of the transmitted data bits.
  - else odd: XNOR of the transmitted data bits.
  - Only the bits selected by word length are used.
- STOP:
  - o_txd=1.
  - Length: OVERSAMPLE ticks for 1 stop bit; 2*OVERSAMPLE ticks for 2 stop bits; 3*OVERSAMPLE/2 ticks when stop=1 and word=5 bits.
  - On completion: o_frame_done=1 for one cycle and state=IDLE.
- Back-to-back frames: a new byte is accepted the cycle after returning to IDLE, giving one PCLK of extra mark. No byte is accepted while not IDLE.
- Break:
  - Live signal, not snapshotted. While i_break_ctrl_bit=1, o_txd=0 regardless of state.
  - Frame sequencing, counters and handshake continue unchanged.
  - When break drops, o_txd shows the current state's bit on the next edge.
- Outputs: o_txd is registered, with no combinational path from inputs. o_tsr_empty = (state==IDLE).
- Inputs during IDLE: i_baud_tick is ignored. i_tx_valid is ignored outside IDLE.

Test Plan:
- 8N1: word=11, PEN=0, stop=0; send 0xA5 → o_txd per 16-tick bit: 0,1,0,1,0,0,1,0,1,1. o_frame_done pulses after 160 ticks; o_tsr_empty=0 throughout, then 1.
- 7E1: word=10, PEN=1, EPS=1; send 0x41 → data bits 1,0,0,0,0,0,1, then parity 0, then stop 1. Bit 7 of the byte is ignored. Frame = 160 ticks.
- 5O, 1.5 stop: word=00, PEN=1, EPS=0, stop=1; send 0x1F → data 1,1,1,1,1, parity 0, stop held 24 ticks. Frame = 136 ticks. Repeat with word=11 → 2 stop bits = 32 ticks.
- Stick parity and LCR snapshot: PEN=1, stick=1, EPS=0 → parity bit 1; EPS=1 → parity bit 0 regardless of data. Flip EPS mid-frame → current frame is unchanged and the next frame uses the new value.
- Back-to-back and handshake: hold i_tx_valid=1 with 0x55 then 0xAA → exactly two acceptances. o_tx_ready=0 during frames. Exactly one PCLK of idle mark between the frames.
- Break and reset mid-frame: assert break during DATA → o_txd=0 and o_frame_done still at tick 160. Assert PRESET during PARITY → next edge o_txd=1, o_tx_ready=1, o_tsr_empty=1, and no o_frame_done pulse.
